// File: rtl/gpr_bank.sv
// Parametrised register bank: NUM_RD combinational read ports, two prioritised
// write ports, optional write-to-read bypass and a per-register pending-write scoreboard.
module gpr_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     zero_wr_err,
    output logic                     wr_conflict
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              zero_wr_err_q;
    logic              zero_wr_err_d;
    logic              wr_conflict_q;
    logic              wr_conflict_d;
    logic [ADDR_W-1:0] raddr_s [NUM_RD];

    // Next-state for storage and scoreboard; port 1 beats port 0, a claim beats a clear.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if ((ZERO_REG != 0) && (i == 0)) begin
                regs_d[i] = '0;
                busy_d[i] = 1'b0;
            end else begin
                if (we1 && (wa1 == ADDR_W'(i))) begin
                    regs_d[i] = wd1;
                end else if (we0 && (wa0 == ADDR_W'(i))) begin
                    regs_d[i] = wd0;
                end else begin
                    regs_d[i] = regs_q[i];
                end

                if (claim_en && (claim_addr == ADDR_W'(i))) begin
                    busy_d[i] = 1'b1;
                end else if ((we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)))) begin
                    busy_d[i] = 1'b0;
                end else begin
                    busy_d[i] = busy_q[i];
                end
            end
        end
    end

    // Error flag next-state: same-index dual write, and any write aimed at the hardwired zero register.
    always_comb begin
        wr_conflict_d = we0 && we1 && (wa0 == wa1);
        zero_wr_err_d = (ZERO_REG != 0) &&
                        ((we0 && (wa0 == ZERO_IDX)) || (we1 && (wa1 == ZERO_IDX)));
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            zero_wr_err_q <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            zero_wr_err_q <= zero_wr_err_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Combinational read ports; bypass is suppressed while reset holds the bank cleared.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            raddr_s[k] = rd_addr[k*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (raddr_s[k] == ZERO_IDX)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if ((BYPASS != 0) && reset && we1 && (wa1 == raddr_s[k])) begin
                rd_data[k*DATA_W +: DATA_W] = wd1;
            end else if ((BYPASS != 0) && reset && we0 && (wa0 == raddr_s[k])) begin
                rd_data[k*DATA_W +: DATA_W] = wd0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs_q[raddr_s[k]];
            end
            rd_busy[k] = busy_q[raddr_s[k]];
        end
    end

    assign zero_wr_err = zero_wr_err_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_gpr_bank.sv
// Scoreboard bench: instance A (4 ports, bypass) and instance B (2 ports, no bypass)
// share the write/claim inputs; expectations are queued and checked at the falling edge.
module tb_gpr_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [19:0]  rd_addr_a;
    logic [9:0]   rd_addr_b;
    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic         we0, we1, claim_en;
    logic [4:0]   wa0, wa1, claim_addr;
    logic [31:0]  wd0, wd1;
    logic         zero_a, conf_a, zero_b, conf_b;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] vid = 16'd0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    assign rd_addr_b = rd_addr_a[9:0];

    gpr_bank #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) u_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .zero_wr_err(zero_a), .wr_conflict(conf_a)
    );

    gpr_bank #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) u_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .zero_wr_err(zero_b), .wr_conflict(conf_b)
    );

    // kinds: 0-3 A port data, 4 A busy, 5 A flags {zero,conf}, 6 B port0 data, 7 B busy0, 8 B flags
    function automatic logic [31:0] actual(input logic [3:0] kind);
        case (kind)
            4'd0:    return rd_data_a[31:0];
            4'd1:    return rd_data_a[63:32];
            4'd2:    return rd_data_a[95:64];
            4'd3:    return rd_data_a[127:96];
            4'd4:    return {28'd0, rd_busy_a};
            4'd5:    return {30'd0, zero_a, conf_a};
            4'd6:    return rd_data_b[31:0];
            4'd7:    return {31'd0, rd_busy_b[0]};
            4'd8:    return {30'd0, zero_b, conf_b};
            default: return 32'hXXXX_XXXX;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = actual(e.kind);
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL vec%0d kind%0d: got %08h, expected %08h", e.id, e.kind, act, e.exp);
            end
        end
    end

    task automatic push(input logic [3:0] kind, input logic [31:0] val);
        sb.push_back({vid, kind, val});
        vid = vid + 16'd1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        claim_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3);
        rd_addr_a = {a3, a2, a1, a0};
    endtask

    initial begin
        reset = 1'b0;
        idle();
        wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0; claim_addr = 5'd0;
        rd(5'd7, 5'd3, 5'd5, 5'd9);

        cyc();
        for (int k = 0; k < 4; k++) push(4'(k), 32'd0);
        push(4'd4, 32'd0); push(4'd5, 32'd0); push(4'd6, 32'd0); push(4'd7, 32'd0); push(4'd8, 32'd0);
        cyc();
        reset = 1'b1;

        for (int a = 0; a < 32; a++) begin
            logic [4:0] x;
            cyc();
            x = 5'(a);
            rd(x, x + 5'd1, x + 5'd2, x + 5'd3);
            for (int k = 0; k < 4; k++) push(4'(k), 32'd0);
            push(4'd4, 32'd0); push(4'd6, 32'd0); push(4'd7, 32'd0);
        end

        // bypass versus stored-only read of a fresh write
        cyc();
        rd(5'd3, 5'd0, 5'd0, 5'd0);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h1234_5678;
        push(4'd0, 32'h1234_5678); push(4'd1, 32'd0); push(4'd6, 32'd0);
        cyc();
        idle();
        push(4'd0, 32'h1234_5678); push(4'd6, 32'h1234_5678);

        // dual write to the same index
        cyc();
        rd(5'd5, 5'd5, 5'd0, 5'd0);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hAAAA_0000;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h0000_BBBB;
        push(4'd0, 32'h0000_BBBB); push(4'd1, 32'h0000_BBBB); push(4'd6, 32'd0); push(4'd5, 32'd0);
        cyc();
        idle();
        push(4'd0, 32'h0000_BBBB); push(4'd6, 32'h0000_BBBB); push(4'd5, 32'd1); push(4'd8, 32'd1);
        cyc();
        push(4'd5, 32'd0); push(4'd8, 32'd0);

        // write and claim of the zero register
        cyc();
        rd(5'd0, 5'd3, 5'd0, 5'd0);
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        claim_en = 1'b1; claim_addr = 5'd0;
        push(4'd0, 32'd0); push(4'd6, 32'd0); push(4'd1, 32'h1234_5678);
        cyc();
        idle();
        push(4'd0, 32'd0); push(4'd4, 32'd0); push(4'd5, 32'd2); push(4'd8, 32'd2); push(4'd6, 32'd0);
        cyc();
        push(4'd5, 32'd0); push(4'd4, 32'd0);

        // scoreboard: claim, claim+write (set wins), write alone clears
        cyc();
        rd(5'd9, 5'd3, 5'd9, 5'd0);
        claim_en = 1'b1; claim_addr = 5'd9;
        push(4'd4, 32'd0);
        cyc();
        claim_en = 1'b1; claim_addr = 5'd9;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0099;
        push(4'd4, 32'h0000_0005); push(4'd0, 32'h0000_0099); push(4'd6, 32'd0); push(4'd7, 32'd1);
        cyc();
        claim_en = 1'b0;
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000_0077;
        push(4'd4, 32'h0000_0005); push(4'd0, 32'h0000_0077); push(4'd6, 32'h0000_0099); push(4'd7, 32'd1);
        cyc();
        idle();
        push(4'd4, 32'd0); push(4'd0, 32'h0000_0077); push(4'd6, 32'h0000_0077); push(4'd7, 32'd0);

        // all four ports on one register, written by port 1 and claimed together
        cyc();
        rd(5'd2, 5'd2, 5'd2, 5'd2);
        we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h00C0_FFEE;
        claim_en = 1'b1; claim_addr = 5'd2;
        for (int k = 0; k < 4; k++) push(4'(k), 32'h00C0_FFEE);
        push(4'd4, 32'd0); push(4'd6, 32'd0);
        cyc();
        idle();
        for (int k = 0; k < 4; k++) push(4'(k), 32'h00C0_FFEE);
        push(4'd4, 32'h0000_000F); push(4'd6, 32'h00C0_FFEE); push(4'd7, 32'd1);

        // asynchronous reset mid-run
        cyc();
        rd(5'd7, 5'd2, 5'd3, 5'd9);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hDEAD_BEEF;
        push(4'd0, 32'hDEAD_BEEF); push(4'd4, 32'h0000_0002); push(4'd6, 32'd0);
        cyc();
        idle();
        push(4'd0, 32'hDEAD_BEEF); push(4'd6, 32'hDEAD_BEEF); push(4'd2, 32'h1234_5678); push(4'd3, 32'h0000_0077);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) push(4'(k), 32'd0);
        push(4'd4, 32'd0); push(4'd5, 32'd0); push(4'd6, 32'd0); push(4'd7, 32'd0);
        cyc();
        reset = 1'b1;
        push(4'd0, 32'd0); push(4'd2, 32'd0); push(4'd4, 32'd0);

        // normal operation after reset release
        cyc();
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_0001;
        cyc();
        idle();
        push(4'd0, 32'h0000_0001); push(4'd6, 32'h0000_0001);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpr_bank.md
Name: gpr_bank

Overview:
- Parametrised general-purpose register bank. Successor to the single-write, two-read GPR used by the datapath.
- Adds a configurable number of read ports, two write ports with fixed priority, and optional write-to-read bypass.
- Adds a per-register pending-write scoreboard, so the pipeline control can detect RAW hazards.
- Sits between decode (reads, claims) and writeback (writes, clears).

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register index width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching reads; 0 = reads return stored value only.
- ZERO_REG, 1: 1 = register 0 reads 0 and ignores writes/claims; 0 = register 0 is ordinary.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd_addr  input  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  read data, packed the same way.
- rd_busy  output  NUM_RD  1 = register addressed by read port k has a pending write.
- we0  input  1  write enable, port 0 (writeback).
- wa0  input  ADDR_W  write index, port 0.
- wd0  input  DATA_W  write data, port 0.
- we1  input  1  write enable, port 1 (load return).
- wa1  input  ADDR_W  write index, port 1.
- wd1  input  DATA_W  write data, port 1.
- claim_en  input  1  mark claim_addr as pending-write.
- claim_addr  input  ADDR_W  register being claimed.
- zero_wr_err  output  1  registered one-cycle pulse on any enabled write to register 0 when ZERO_REG=1.
- wr_conflict  output  1  registered one-cycle pulse when we0 and we1 target the same index.

Behaviour:
- Reset (reset low, asynchronous): all registers clear to 0; all busy bits clear; zero_wr_err and wr_conflict go to 0. rd_data then reads 0 for all addresses and rd_busy reads 0.
- Reset released: normal operation from the next rising clk edge. A reset asserted mid-cycle overrides any write or claim in flight.
- Reads are combinational (zero latency):
  - rd_data[k] = stored value of rd_addr[k].
  - If BYPASS=1 and a write in the current cycle matches rd_addr[k], rd_data[k] = that write's data instead. Port 1 takes priority over port 0 when both match.
  - If ZERO_REG=1 and rd_addr[k]==0, rd_data[k]=0 regardless of bypass.
- Writes occur on the rising clk edge when the corresponding we is high.
  - If we0 and we1 target the same index, port 1 wins, port 0's data is discarded, and wr_conflict pulses the next cycle.
  - With ZERO_REG=1, writes to index 0 have no effect and zero_wr_err pulses the next cycle. Both flags may pulse in the same cycle.
- Scoreboard: one busy bit per register, updated on the rising edge.
  - claim_en sets busy[claim_addr].
  - An enabled write clears busy[wa].
  - If a claim and a write hit the same index in the same cycle, set wins: the new producer is outstanding.
  - Claiming an already-busy register leaves it busy (no counting).
  - ZERO_REG=1: busy[0] is held at 0.
- rd_busy[k] = busy[rd_addr[k]] as of the start of the cycle. A same-cycle write does not clear it combinationally; the clear is visible the following cycle.
- Multiple read ports may address the same register; each returns identical data and busy.

Test Plan:
- Reset, then read all addresses on every port -> rd_data=0 and rd_busy=0 everywhere. Assert reset mid-run after writing 0xDEADBEEF to r7 -> r7 reads 0 immediately, without waiting for a clock edge.
- we0 writes 0x12345678 to r3 while port 0 reads r3:
  - BYPASS=1 -> 0x12345678 in the same cycle.
  - BYPASS=0 -> old value 0 in that cycle, 0x12345678 the next cycle.
- we0 (r5, 0xAAAA0000) and we1 (r5, 0x0000BBBB) in the same cycle -> r5=0x0000BBBB and wr_conflict=1 for exactly one cycle. Same case with BYPASS=1 -> the same-cycle read returns 0x0000BBBB.
- ZERO_REG=1, write 0xFFFFFFFF to r0 -> r0 still reads 0, zero_wr_err pulses once, and claim of r0 leaves rd_busy 0.
- Claim r9 -> rd_busy=1 the next cycle. Then claim r9 and we0 r9 in the same cycle -> still busy. Then write r9 alone -> busy clears the following cycle.
- NUM_RD=4, all four ports address r2 holding 0x00C0FFEE -> all ports return 0x00C0FFEE with matching busy.
